fir_tdm: RTL and testbench

Parametrised, time-multiplexed FIR filter that succeeds the fixed-coefficient `fir` core in the Tiny Tapeout wrapper. It has run-time-loadable coefficients, a valid/ready input handshake and a configurable tap count. One signed multiplier-accumulator is shared across all taps, and samples are kept in a circular delay line. The block sits between the pad-level input byte and the 16-bit output bus (`uo_out`/`uio_out`).

---
 rtl/fir_pkg.sv | 29 ++
 rtl/fir_tdm_if.sv | 31 +++
 rtl/fir_mac.sv | 27 ++
 rtl/fir_tdm.sv | 107 ++++++++++
 tb/tb_fir_tdm.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared types and helpers for the time-multiplexed FIR.
//   fir_state_t : controller states (IDLE waits for a sample, MAC runs the taps)
//   fir_acc_w   : accumulator width that cannot overflow over TAPS products
//   sat_shift   : arithmetic right shift (floor) followed by clamp to ow bits
package fir_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MAC  = 1'b1
  } fir_state_t;

  function automatic int fir_acc_w(input int dw, input int cw, input int taps);
    return dw + cw + $clog2(taps);
  endfunction

  // Works on a 64-bit carrier so one function serves any accumulator and
  // output width up to 64; the caller truncates to ow bits afterwards.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] v,
                                                  input int sh, input int ow);
    logic signed [63:0] s, hi, lo;
    s  = v >>> sh;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/fir_tdm_if.sv
// fir_tdm_if: sample handshake, coefficient write port and result bus.
//   master : producer/consumer side (drives samples and coefficient writes)
//   slave  : filter side (drives in_ready, busy and the result)
interface fir_tdm_if #(
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int TAPS = 8,
  parameter int OW   = 16
);
  localparam int KW = $clog2(TAPS);

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 coef_we;
  logic [KW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 out_valid;
  logic signed [OW-1:0] out_data;
  logic                 busy;

  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_data,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_data,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/fir_mac.sv
// fir_mac: registered signed multiply-accumulate shared by all taps.
//   clr : zero the accumulator (wins over en)
//   en  : acc <= acc + a*b
//   a,b : signed sample / coefficient
//   acc : running sum, AW bits signed
module fir_mac #(
  parameter int DW = 8,
  parameter int CW = 8,
  parameter int AW = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [CW-1:0] b,
  output logic signed [AW-1:0] acc
);
  // Full product always fits in DW+CW signed bits.
  logic signed [DW+CW-1:0] prod;
  assign prod = (DW+CW)'(a) * (DW+CW)'(b);

  always_ff @(posedge clk) begin
    if (rst || clr) acc <= '0;
    else if (en)    acc <= acc + AW'(prod);
  end
endmodule

// File: rtl/fir_tdm.sv
// fir_tdm: time-multiplexed FIR, y[n] = sat((sum c[k]*x[n-k]) >>> SHIFT).
//   clk, rst : clock, synchronous active-high reset
//   bus      : fir_tdm_if slave -- in_valid/in_ready/in_data sample handshake,
//              coef_we/coef_addr/coef_data coefficient writes (IDLE only),
//              out_valid pulse + out_data result, busy while the MAC runs.
// One sample is accepted in IDLE, then TAPS MAC cycles walk the circular delay
// line backwards from the newly written slot.
module fir_tdm
  import fir_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int TAPS  = 8,
  parameter int OW    = 16,
  parameter int SHIFT = 0
) (
  input logic     clk,
  input logic     rst,
  fir_tdm_if.slave bus
);
  localparam int KW = $clog2(TAPS);
  localparam int AW = fir_acc_w(DW, CW, TAPS);

  fir_state_t state_q, state_d;

  logic [KW-1:0]             k_q, wp_q, base_q, rd_idx;
  logic [TAPS-1:0][DW-1:0]   dly_q;
  logic [TAPS-1:0][CW-1:0]   coef_q;
  logic                      accept, mac_en, last, coef_wr, out_valid_q;
  logic signed [OW-1:0]      out_q, out_now;
  logic signed [AW-1:0]      acc;

  assign bus.in_ready = (state_q == IDLE);
  assign bus.busy     = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    mac_en  = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: if (bus.in_valid) begin
        accept  = 1'b1;
        state_d = MAC;
      end
      MAC: begin
        mac_en = 1'b1;
        if (k_q == KW'(TAPS - 1)) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Writes are only taken in IDLE; out-of-range addresses (TAPS not a power
  // of two) are dropped.
  assign coef_wr = bus.coef_we && (state_q == IDLE) &&
                   ({1'b0, bus.coef_addr} < (KW+1)'(TAPS));

  // (base - k) mod TAPS; the add-back only matters when TAPS is not 2^KW.
  assign rd_idx = base_q - k_q + ((base_q < k_q) ? KW'(TAPS) : '0);

  fir_mac #(.DW(DW), .CW(CW), .AW(AW)) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (mac_en),
    .a   ($signed(dly_q[rd_idx])),
    .b   ($signed(coef_q[k_q])),
    .acc (acc)
  );

  // The accumulator holds the final sum during the out_valid cycle, so the
  // result is presented straight from it then and latched into out_q at the
  // following edge, before a new accept can clear the accumulator.
  assign out_now       = OW'(sat_shift(64'(acc), SHIFT, OW));
  assign bus.out_data  = out_valid_q ? out_now : out_q;
  assign bus.out_valid = out_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      wp_q        <= '0;
      base_q      <= '0;
      dly_q       <= '0;
      coef_q      <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= last;
      if (out_valid_q) out_q <= out_now;
      if (coef_wr) coef_q[bus.coef_addr] <= bus.coef_data;
      if (accept) begin
        dly_q[wp_q] <= bus.in_data;
        base_q      <= wp_q;
        wp_q        <= (wp_q == KW'(TAPS - 1)) ? '0 : wp_q + KW'(1);
        k_q         <= '0;
      end else if (mac_en) begin
        k_q <= last ? '0 : k_q + KW'(1);
      end
    end
  end
endmodule

// File: tb/tb_fir_tdm.sv
module tb_fir_tdm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_tdm_if #(.DW(8), .CW(8), .TAPS(8), .OW(16)) bus ();
  fir_tdm_if #(.DW(8), .CW(8), .TAPS(8), .OW(16)) bus2 ();

  fir_tdm #(.DW(8), .CW(8), .TAPS(8), .OW(16), .SHIFT(0)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  fir_tdm #(.DW(8), .CW(8), .TAPS(8), .OW(16), .SHIFT(4)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---- reference model + scoreboard for dut ----
  typedef struct { longint val; int cyc; } exp_t;
  exp_t   sb[$];
  longint obs[$];
  longint m_hist[8];
  longint m_coef[8];
  longint last_out = 0;
  int     cyc = 0;
  int     last_acc = -1;
  bit     t3 = 1'b0;

  function automatic longint model_y();
    longint s = 0;
    for (int i = 0; i < 8; i++) s += m_coef[i] * m_hist[i];
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change just after posedge, so at negedge they show what the next
  // edge will see; out_valid/out_data are stable here too.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin m_hist[i] = 0; m_coef[i] = 0; end
      sb.delete();
    end else begin
      if (bus.out_valid) begin
        if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
        else begin
          e = sb.pop_front();
          chk("y", bus.out_data, e.val);
          chk("latency", cyc - e.cyc, 8);
          last_out = bus.out_data;
          obs.push_back(bus.out_data);
        end
      end
      if (bus.coef_we && bus.in_ready) m_coef[bus.coef_addr] = bus.coef_data;
      if (bus.in_valid && bus.in_ready) begin
        for (int i = 7; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = bus.in_data;
        e.val = model_y();
        e.cyc = cyc + 1;
        sb.push_back(e);
        if (t3 && last_acc >= 0) chk("accept_gap", cyc + 1 - last_acc, 9);
        last_acc = cyc + 1;
      end
    end
  end

  // ---- driver tasks (called just after a posedge) ----
  task automatic wait_accept();
    int n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        return;
      end
      if (++n > 50) begin
        chk("accept_timeout", 0, 1);
        return;
      end
    end
  endtask

  task automatic send(input int x);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'(x);
    wait_accept();
    bus.in_valid = 1'b0;
  endtask

  task automatic wcoef(input int a, input int d);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 3'(a);
    bus.coef_data = 8'(d);
    @(posedge clk); #1;
    bus.coef_we   = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin @(posedge clk); n++; end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic run2(input int x, input int exp);
    int n = 0;
    bus2.in_valid = 1'b1;
    bus2.in_data  = 8'(x);
    do begin @(negedge clk); n++; end while (!bus2.in_ready && n < 50);
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus2.out_valid && n < 30);
    if (!bus2.out_valid) chk("shift4_timeout", 0, 1);
    else chk("shift4_y", bus2.out_data, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.in_valid = 0; bus.in_data = 0; bus.coef_we = 0; bus.coef_addr = 0; bus.coef_data = 0;
    bus2.in_valid = 0; bus2.in_data = 0; bus2.coef_we = 0; bus2.coef_addr = 0; bus2.coef_data = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);

    // 1: impulse
    for (int k = 0; k < 8; k++) wcoef(k, k + 1);
    obs.delete();
    send(1);
    for (int i = 0; i < 8; i++) send(0);
    drain();
    chk("impulse_count", obs.size(), 9);
    if (obs.size() == 9)
      for (int i = 0; i < 9; i++) chk("impulse", obs[i], (i < 8) ? i + 1 : 0);

    // 2: saturation
    for (int k = 0; k < 8; k++) wcoef(k, -128);
    for (int i = 0; i < 8; i++) send(-128);
    drain();
    chk("sat_pos", last_out, 32767);
    for (int i = 0; i < 8; i++) send(127);
    drain();
    chk("sat_neg", last_out, -32768);
    repeat (5) @(posedge clk);
    #1 chk("out_hold", bus.out_data, -32768);

    // 3: back-pressure, in_valid held high
    t3 = 1'b1; last_acc = -1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_data = 8'(i + 1);
      wait_accept();
    end
    bus.in_valid = 1'b0;
    t3 = 1'b0;
    drain();

    // 4: coefficient write during MAC ignored; simultaneous write+accept taken
    wcoef(0, 2);
    for (int k = 1; k < 8; k++) wcoef(k, 0);
    send(10);
    wcoef(0, 5);               // lands in MAC, must be dropped
    drain();
    chk("c0_old_a", last_out, 20);
    send(3);
    drain();
    chk("c0_old_b", last_out, 6);
    bus.coef_we = 1'b1; bus.coef_addr = 3'd0; bus.coef_data = 8'sd5;
    bus.in_valid = 1'b1; bus.in_data = 8'sd2;
    wait_accept();
    bus.coef_we = 1'b0; bus.in_valid = 1'b0;
    drain();
    chk("c0_same_cycle", last_out, 10);

    // 5: reset mid-MAC
    send(4);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_out_data", bus.out_data, 0);
    repeat (12) @(posedge clk);
    #1;
    chk("mid_rst_no_result", sb.size(), 0);
    send(1);
    drain();
    chk("post_rst_impulse", last_out, 0);

    // 6: SHIFT=4 floor rounding on dut2
    bus2.coef_we = 1'b1; bus2.coef_addr = 3'd0; bus2.coef_data = 8'sd1;
    @(posedge clk); #1;
    bus2.coef_we = 1'b0;
    run2(-1, -1);
    run2(31, 1);
    run2(-17, -2);
    run2(16, 1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
